// File: rtl/demux1x4_seq.sv
// Sequential 1-to-4 demultiplexer. Each output channel has a one-entry
// valid/ready buffer. A shared counter tracks how many words were accepted.
module demux1x4_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] D,
  input  logic         S0,
  input  logic         S1,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] Y0,
  output logic [W-1:0] Y1,
  output logic [W-1:0] Y2,
  output logic [W-1:0] Y3,
  output logic         V0,
  output logic         V1,
  output logic         V2,
  output logic         V3,
  input  logic         R0,
  input  logic         R1,
  input  logic         R2,
  input  logic         R3,
  output logic [7:0]   xfer_count
);

  logic [1:0]   sel;
  logic [3:0]   rdy;
  logic [3:0]   full_p0;
  logic [W-1:0] data_p0 [4];
  logic [7:0]   count_p0;
  logic         accept;

  assign sel = {S1, S0};
  assign rdy = {R3, R2, R1, R0};

  // The selected buffer can take a word if it is empty or is draining on this same edge.
  assign in_ready = !full_p0[sel] || rdy[sel];
  assign accept   = in_valid && in_ready;

  // Stage p0: per-channel buffers and the accept counter
  always_ff @(posedge clk) begin
    if (rst) begin
      full_p0  <= '0;
      count_p0 <= '0;
      for (int k = 0; k < 4; k++) begin
        data_p0[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (accept && (sel == 2'(k))) begin
          data_p0[k] <= D;
          full_p0[k] <= 1'b1;
        end else if (full_p0[k] && rdy[k]) begin
          full_p0[k] <= 1'b0;
        end
      end
      if (accept) begin
        count_p0 <= count_p0 + 8'd1;
      end
    end
  end

  assign Y0 = data_p0[0];
  assign Y1 = data_p0[1];
  assign Y2 = data_p0[2];
  assign Y3 = data_p0[3];
  assign V0 = full_p0[0];
  assign V1 = full_p0[1];
  assign V2 = full_p0[2];
  assign V3 = full_p0[3];
  assign xfer_count = count_p0;

endmodule
